// File: rtl/oven_ctrl_if.sv
// Front-panel / setpoint / display bundle between the oven timer datapath and oven_ctrl.
// The master side drives keys, door and setpoint; the controller is the slave.
interface oven_ctrl_if;
    logic       key_start;
    logic       key_stop;
    logic       door_open;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic [5:0] rem_min;
    logic [5:0] rem_sec;
    logic [1:0] state;
    logic       heater_en;
    logic       lamp;
    logic       beep;
    logic       done;

    modport master (
        output key_start, key_stop, door_open, set_min, set_sec,
        input  rem_min, rem_sec, state, heater_en, lamp, beep, done
    );

    modport slave (
        input  key_start, key_stop, door_open, set_min, set_sec,
        output rem_min, rem_sec, state, heater_en, lamp, beep, done
    );
endinterface

// File: rtl/oven_ctrl.sv
// Cook-cycle controller: IDLE/COOK/PAUSE/DONE sequencing, 1 Hz countdown of the
// remaining time, and registered heater/lamp/beeper drive.
module oven_ctrl #(
    parameter int TICK_DIV  = 50000000,
    parameter int BEEP_SECS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    oven_ctrl_if.slave  bus
);
    localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int BW = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BSEC_LAST = BW'(BEEP_SECS - 1);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_COOK  = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    logic          r_start_s1, r_start_s2, r_start_d;
    logic          r_stop_s1,  r_stop_s2,  r_stop_d;
    logic          r_door_s1,  r_door_s2;
    logic [1:0]    r_state;
    logic [TW-1:0] r_tick;
    logic [BW-1:0] r_bsec;
    logic [5:0]    r_min, r_sec;
    logic          r_heater, r_lamp, r_beep, r_done;

    logic          w_start_ev, w_stop_ev;
    logic [5:0]    w_min_c, w_sec_c;
    logic          w_set_zero, w_tick_wrap;
    logic [1:0]    w_state_nxt;
    logic [TW-1:0] w_tick_nxt;
    logic [BW-1:0] w_bsec_nxt;
    logic [5:0]    w_min_nxt, w_sec_nxt;
    logic          w_done_nxt;

    // Keys are active-low: a press is a 1->0 transition of the synchronized level,
    // so a held key yields one event. Sync flops clear to 0 so reset release never
    // looks like a press.
    assign w_start_ev  = r_start_d & ~r_start_s2;
    assign w_stop_ev   = r_stop_d  & ~r_stop_s2;

    assign w_min_c     = (bus.set_min > 6'd59) ? 6'd59 : bus.set_min;
    assign w_sec_c     = (bus.set_sec > 6'd59) ? 6'd59 : bus.set_sec;
    assign w_set_zero  = (w_min_c == 6'd0) && (w_sec_c == 6'd0);
    assign w_tick_wrap = (r_tick == TICK_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_bsec_nxt  = r_bsec;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_min_nxt = w_min_c;
                w_sec_nxt = w_sec_c;
                if (w_start_ev && !w_stop_ev && !r_door_s2 && !w_set_zero) begin
                    w_state_nxt = S_COOK;
                    w_tick_nxt  = '0;
                end
            end
            S_COOK: begin
                // Stop/door win over a coincident tick: time and tick counter hold.
                if (w_stop_ev || r_door_s2) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_tick_wrap) begin
                    w_tick_nxt = '0;
                    if (r_sec != 6'd0) begin
                        w_sec_nxt = r_sec - 6'd1;
                    end else if (r_min != 6'd0) begin
                        w_sec_nxt = 6'd59;
                        w_min_nxt = r_min - 6'd1;
                    end
                    if (r_min == 6'd0 && r_sec <= 6'd1) begin
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                        w_bsec_nxt  = '0;
                    end
                end else begin
                    w_tick_nxt = r_tick + 1'b1;
                end
            end
            S_PAUSE: begin
                if (w_stop_ev)
                    w_state_nxt = S_IDLE;
                else if (w_start_ev && !r_door_s2)
                    w_state_nxt = S_COOK;
            end
            default: begin
                // DONE reuses the tick counter to time the beeper seconds.
                if (w_stop_ev || r_door_s2) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tick_wrap) begin
                    w_tick_nxt = '0;
                    if (r_bsec == BSEC_LAST)
                        w_state_nxt = S_IDLE;
                    else
                        w_bsec_nxt = r_bsec + 1'b1;
                end else begin
                    w_tick_nxt = r_tick + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_start_s1 <= 1'b0;
            r_start_s2 <= 1'b0;
            r_start_d  <= 1'b0;
            r_stop_s1  <= 1'b0;
            r_stop_s2  <= 1'b0;
            r_stop_d   <= 1'b0;
            r_door_s1  <= 1'b0;
            r_door_s2  <= 1'b0;
            r_state    <= S_IDLE;
            r_tick     <= '0;
            r_bsec     <= '0;
            r_min      <= 6'd0;
            r_sec      <= 6'd0;
            r_heater   <= 1'b0;
            r_lamp     <= 1'b0;
            r_beep     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_start_s1 <= bus.key_start;
            r_start_s2 <= r_start_s1;
            r_start_d  <= r_start_s2;
            r_stop_s1  <= bus.key_stop;
            r_stop_s2  <= r_stop_s1;
            r_stop_d   <= r_stop_s2;
            r_door_s1  <= bus.door_open;
            r_door_s2  <= r_door_s1;
            r_state    <= w_state_nxt;
            r_tick     <= w_tick_nxt;
            r_bsec     <= w_bsec_nxt;
            r_min      <= w_min_nxt;
            r_sec      <= w_sec_nxt;
            r_heater   <= (w_state_nxt == S_COOK);
            r_lamp     <= (w_state_nxt == S_COOK) | r_door_s2;
            r_beep     <= (w_state_nxt == S_DONE);
            r_done     <= w_done_nxt;
        end
    end

    assign bus.state     = r_state;
    assign bus.rem_min   = r_min;
    assign bus.rem_sec   = r_sec;
    assign bus.heater_en = r_heater;
    assign bus.lamp      = r_lamp;
    assign bus.beep      = r_beep;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_oven_ctrl.sv
// Directed bench for oven_ctrl with TICK_DIV=4, BEEP_SECS=2; expected values hand-derived.
module tb_oven_ctrl;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   n_cook_ent;
    int   ent_base;
    logic [1:0] prev_state;

    oven_ctrl_if ifc ();

    oven_ctrl #(.TICK_DIV(4), .BEEP_SECS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts COOK entries, sampled on the inactive edge.
    initial begin
        n_cook_ent = 0;
        prev_state = 2'b00;
    end
    always @(negedge clk) begin
        if (ifc.state == 2'b01 && prev_state != 2'b01)
            n_cook_ent = n_cook_ent + 1;
        prev_state = ifc.state;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Key low for three edges: the state change lands on the third edge.
    task automatic press_start();
        ifc.key_start = 1'b0;
        step(3);
        ifc.key_start = 1'b1;
    endtask

    task automatic press_stop();
        ifc.key_stop = 1'b0;
        step(3);
        ifc.key_stop = 1'b1;
    endtask

    task automatic set_time(input int m, input int s);
        ifc.set_min = 6'(m);
        ifc.set_sec = 6'(s);
        step(1);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        ifc.key_start = 1'b1;
        ifc.key_stop  = 1'b1;
        ifc.door_open = 1'b0;
        ifc.set_min   = 6'd0;
        ifc.set_sec   = 6'd2;
        step(2);
        chk("rst_state", ifc.state, 0);
        chk("rst_rem_sec", ifc.rem_sec, 0);
        chk("rst_heater", ifc.heater_en, 0);
        chk("rst_lamp", ifc.lamp, 0);
        rst_n = 1'b1;
        step(1);
        chk("idle_track_sec", ifc.rem_sec, 2);
        step(3);

        // Normal cook 0:02
        press_start();
        chk("cook_entry_state", ifc.state, 1);
        chk("cook_entry_heater", ifc.heater_en, 1);
        chk("cook_entry_lamp", ifc.lamp, 1);
        step(3);
        chk("cook_pre_dec", ifc.rem_sec, 2);
        step(1);
        chk("cook_dec1", ifc.rem_sec, 1);
        step(4);
        chk("done_rem", ifc.rem_sec, 0);
        chk("done_state", ifc.state, 3);
        chk("done_pulse", ifc.done, 1);
        chk("done_beep", ifc.beep, 1);
        chk("done_heater", ifc.heater_en, 0);
        step(1);
        chk("done_pulse_end", ifc.done, 0);
        step(6);
        chk("beep_last", ifc.beep, 1);
        step(1);
        chk("auto_idle_state", ifc.state, 0);
        chk("auto_idle_beep", ifc.beep, 0);
        step(1);
        chk("idle_retrack", ifc.rem_sec, 2);

        // Minute borrow 1:00
        set_time(1, 0);
        step(2);
        press_start();
        step(4);
        chk("borrow_min", ifc.rem_min, 0);
        chk("borrow_sec", ifc.rem_sec, 59);
        chk("borrow_heater", ifc.heater_en, 1);
        press_stop();
        chk("stop_pause", ifc.state, 2);
        chk("stop_pause_rem", ifc.rem_sec, 59);
        step(3);
        press_stop();
        chk("stop_cancel", ifc.state, 0);
        step(3);

        // Door pause at 0:05
        set_time(0, 5);
        step(2);
        press_start();
        step(4);
        chk("door_pre_rem", ifc.rem_sec, 4);
        ifc.door_open = 1'b1;
        step(3);
        chk("door_pause_state", ifc.state, 2);
        chk("door_pause_heater", ifc.heater_en, 0);
        chk("door_pause_lamp", ifc.lamp, 1);
        step(5);
        chk("door_hold_rem", ifc.rem_sec, 4);
        press_start();
        chk("door_open_start_ign", ifc.state, 2);
        step(3);
        ifc.door_open = 1'b0;
        step(3);
        chk("door_closed_lamp", ifc.lamp, 0);
        press_start();
        chk("resume_state", ifc.state, 1);
        chk("resume_rem", ifc.rem_sec, 4);
        step(1);
        chk("resume_tick_hold", ifc.rem_sec, 4);
        step(1);
        chk("resume_dec", ifc.rem_sec, 3);
        press_stop();
        chk("resume_stop", ifc.state, 2);
        step(3);

        // Start and stop together from PAUSE
        ifc.key_start = 1'b0;
        ifc.key_stop  = 1'b0;
        step(3);
        ifc.key_start = 1'b1;
        ifc.key_stop  = 1'b1;
        chk("start_stop_same", ifc.state, 0);
        step(3);

        // Zero setpoint ignored
        set_time(0, 0);
        press_start();
        chk("zero_set_idle", ifc.state, 0);
        chk("zero_set_heater", ifc.heater_en, 0);
        step(3);

        // Clamp
        set_time(60, 63);
        step(1);
        chk("clamp_min", ifc.rem_min, 59);
        chk("clamp_sec", ifc.rem_sec, 59);

        // Held start key for 20 cycles at 1:00
        set_time(1, 0);
        step(2);
        ent_base = n_cook_ent;
        ifc.key_start = 1'b0;
        step(3);
        chk("held_entry", ifc.state, 1);
        step(17);
        ifc.key_start = 1'b1;
        chk("held_rem", ifc.rem_sec, 56);
        chk("held_single_entry", n_cook_ent - ent_base, 1);
        press_stop();
        step(3);
        press_stop();
        chk("held_cancel", ifc.state, 0);
        step(3);

        // Stop during DONE
        set_time(0, 1);
        step(2);
        press_start();
        step(4);
        chk("done2_state", ifc.state, 3);
        press_stop();
        chk("done_stop_state", ifc.state, 0);
        chk("done_stop_beep", ifc.beep, 0);
        step(3);

        // Reset mid-cook at 0:30
        set_time(0, 30);
        step(2);
        press_start();
        step(2);
        chk("pre_rst_cook", ifc.state, 1);
        rst_n = 1'b0;
        step(1);
        chk("midrst_state", ifc.state, 0);
        chk("midrst_rem_sec", ifc.rem_sec, 0);
        chk("midrst_heater", ifc.heater_en, 0);
        chk("midrst_lamp", ifc.lamp, 0);
        chk("midrst_beep", ifc.beep, 0);
        chk("midrst_done", ifc.done, 0);
        rst_n = 1'b1;
        step(1);
        chk("post_rst_sec", ifc.rem_sec, 30);
        chk("post_rst_min", ifc.rem_min, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/oven_ctrl.md
# oven_ctrl

Cook-cycle controller for the oven timer datapath. It takes a minutes/seconds setpoint from the time-setting logic and the front-panel keys and door switch, and sequences the cook cycle through IDLE, COOK, PAUSE and DONE. It owns the 1 Hz countdown and the remaining-time registers, and drives heater, lamp and beeper. Its remaining-time outputs feed the seven-segment display logic.

## Interface
- `TICK_DIV`, default 50000000: clk cycles per countdown second.
- `BEEP_SECS`, default 3: seconds the beeper sounds in DONE before the automatic return to IDLE.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `key_start`, in, 1: start/resume key, active-low, asynchronous to clk.
- `key_stop`, in, 1: pause/cancel key, active-low, asynchronous to clk.
- `door_open`, in, 1: door switch, 1 = open, asynchronous to clk.
- `set_min`, in, 6: setpoint minutes, binary.
- `set_sec`, in, 6: setpoint seconds, binary.
- `rem_min`, out, 6: remaining minutes, binary.
- `rem_sec`, out, 6: remaining seconds, binary.
- `state`, out, 2: IDLE=00, COOK=01, PAUSE=10, DONE=11.
- `heater_en`, out, 1: heater on.
- `lamp`, out, 1: cavity lamp.
- `beep`, out, 1: beeper drive.
- `done`, out, 1: one-cycle pulse on COOK→DONE.

## Operation
- **Input conditioning**
  - `key_start`, `key_stop` and `door_open` each pass through a 2-flop synchronizer.
  - Each key produces a one-cycle press event on the falling edge of its synchronized level.
  - Holding a key generates exactly one event.
- **Setpoint clamp**: any `set_min` or `set_sec` value above 59 is treated as 59.
- **IDLE**
  - `rem_min`/`rem_sec` track the clamped setpoint every cycle (registered).
  - A start event with door closed and setpoint ≠ 0:00 → COOK. The tick counter clears on entry.
  - A start event with the door open or setpoint 0:00 is ignored.
- **COOK**
  - Tick counter counts 0..TICK_DIV-1. On wrap, remaining time decrements.
  - Decrement rule: if sec>0, sec-1. Otherwise sec=59 and min-1.
  - A decrement that results in 0:00 → DONE, with `done` pulsed in the same cycle the state register becomes DONE.
  - A stop event or `door_open` → PAUSE. Remaining time and tick counter both hold.
- **PAUSE**
  - Start event with door closed → COOK. The tick counter resumes from its held value.
  - Stop event → IDLE.
- **DONE**
  - `beep`=1 and a second counter runs.
  - After BEEP_SECS full seconds → IDLE.
  - A stop event or `door_open` → IDLE immediately.
- **Simultaneous events**
  - Stop beats start in the same cycle.
  - In COOK, door open beats a tick wrap: the tick is not applied.
  - A tick landing on 0:01 together with a stop event: stop wins, and the state goes to PAUSE at 0:01.
- **Outputs** (all registered)
  - `heater_en` = (state==COOK).
  - `lamp` = (state==COOK) | door_open_sync.
  - `beep` = (state==DONE).

## Timing
- **Reset**: `rst_n` low at a clk edge sets the following outputs at that edge, regardless of the current state, including mid-cook:
  - `state`=IDLE.
  - `rem_min`=0, `rem_sec`=0.
  - `heater_en`=0, `lamp`=0, `beep`=0, `done`=0.
  - Synchronizers and counters cleared.
- **Key/door latency**: first edge sampling the new input level = edge N. The state and outputs change at edge N+2. Outputs are derived from the next state, so `heater_en` rises at the same edge `state` becomes COOK.
- **First decrement**: TICK_DIV cycles after COOK entry. Subsequent decrements follow every TICK_DIV cycles of COOK time, pauses excluded.
- **DONE return**: automatic return to IDLE happens BEEP_SECS·TICK_DIV cycles after DONE entry.
- **IDLE tracking latency**: `rem_*` follows the setpoint with 1-cycle latency.
- **No wrap-around**: remaining time never decrements below 0:00.

## Test plan
All scenarios use TICK_DIV=4 and BEEP_SECS=2.
- **Reset**: reset asserted mid-COOK at 0:30 → next edge `state`=00, all outputs 0, `rem` equals the setpoint one cycle after release.
- **Normal cook**: set 0:02, door closed, press start → COOK at N+2, then `rem` 0:01 after 4 cycles, 0:00 + `done` pulse + DONE after 8 cycles, then `beep` for 8 cycles → IDLE, `heater_en` 0.
- **Minute borrow**: set 1:00, start → after 4 cycles `rem`=0:59, `heater_en`=1.
- **Door pause**: during COOK at 0:05, open the door → PAUSE, `heater_en`=0, `lamp`=1, `rem` holds. Close the door and press start → COOK, decrements resume. A start press while the door is open is ignored.
- **Priority/ignore cases**:
  - Start and stop pressed in the same cycle from PAUSE → IDLE.
  - Start with setpoint 0:00 → stays IDLE.
  - `set_sec`=63 → `rem_sec`=59.
- **Held key**: hold start for 20 cycles in IDLE → a single COOK entry. Stop during DONE → IDLE immediately, `beep` 0.
